// File: rtl/switch_debounce_2ch_if.sv
// Raw switch inputs and conditioned outputs for the two-channel debouncer.
// master: board/bench side driving raw switches; slave: the debouncer itself.
interface switch_debounce_2ch_if;
  logic sw_a_raw;
  logic sw_b_raw;
  logic a_out;
  logic b_out;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  modport master (
    output sw_a_raw, sw_b_raw,
    input  a_out, b_out, a_rise, a_fall, b_rise, b_fall
  );

  modport slave (
    input  sw_a_raw, sw_b_raw,
    output a_out, b_out, a_rise, a_fall, b_rise, b_fall
  );
endinterface

// File: rtl/switch_debounce_2ch.sv
// Two independent switch debouncers: 2-flop synchronizer plus counting FSM per channel.
// Define SWITCH_DEBOUNCE_EDGE_EN to get registered rise/fall strobes; otherwise they read 0.
module switch_debounce_2ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  switch_debounce_2ch_if.slave sw
);

  typedef enum logic [1:0] {StIdleLo, StWaitHi, StIdleHi, StWaitLo} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       raw;
  logic [1:0]       sync1_q;
  logic [1:0]       s_q;
  logic [1:0]       out_q;
  logic [1:0]       hit_hi;
  logic [1:0]       hit_lo;
  state_e           state_q [2];
  logic [CNT_W-1:0] cnt_q   [2];

  assign raw = {sw.sw_b_raw, sw.sw_a_raw};

  // Interval complete: this edge commits the new level.
  always_comb begin
    hit_hi = '0;
    hit_lo = '0;
    for (int i = 0; i < 2; i++) begin
      hit_hi[i] = (state_q[i] == StWaitHi) && s_q[i] && (cnt_q[i] == CntMax);
      hit_lo[i] = (state_q[i] == StWaitLo) && !s_q[i] && (cnt_q[i] == CntMax);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      s_q     <= '0;
      out_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StIdleLo;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= raw;
      s_q     <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        unique case (state_q[i])
          StIdleLo: begin
            if (s_q[i]) begin
              state_q[i] <= StWaitHi;
              cnt_q[i]   <= CNT_W'(1);
            end else begin
              cnt_q[i] <= '0;
            end
          end
          StWaitHi: begin
            if (!s_q[i]) begin
              state_q[i] <= StIdleLo;
              cnt_q[i]   <= '0;
            end else if (hit_hi[i]) begin
              state_q[i] <= StIdleHi;
              out_q[i]   <= 1'b1;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          StIdleHi: begin
            if (!s_q[i]) begin
              state_q[i] <= StWaitLo;
              cnt_q[i]   <= CNT_W'(1);
            end else begin
              cnt_q[i] <= '0;
            end
          end
          StWaitLo: begin
            if (s_q[i]) begin
              state_q[i] <= StIdleHi;
              cnt_q[i]   <= '0;
            end else if (hit_lo[i]) begin
              state_q[i] <= StIdleLo;
              out_q[i]   <= 1'b0;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_q[i] <= StIdleLo;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign sw.a_out = out_q[0];
  assign sw.b_out = out_q[1];

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [1:0] rise_q;
  logic [1:0] fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= hit_hi;
      fall_q <= hit_lo;
    end
  end

  assign sw.a_rise = rise_q[0];
  assign sw.b_rise = rise_q[1];
  assign sw.a_fall = fall_q[0];
  assign sw.b_fall = fall_q[1];
`else
  assign sw.a_rise = 1'b0;
  assign sw.b_rise = 1'b0;
  assign sw.a_fall = 1'b0;
  assign sw.b_fall = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// Randomized bench for switch_debounce_2ch against a sliding-window level model,
// plus directed scenarios with hand-computed edge numbers (DEBOUNCE_CYCLES = 4).
module tb_switch_debounce_2ch;

  localparam int unsigned D   = 4;
  localparam int          Win = 8;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  switch_debounce_2ch_if bus ();

  switch_debounce_2ch #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: the FSM sees each raw sample two edges later (zeros right after reset);
  // the output takes a new level once the last D+1 seen samples all carry it.
  bit rh   [2][2];
  bit win  [2][Win];
  int ns   [2];
  bit mout [2];
  bit mrise[2];
  bit mfall[2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      mout[c] = 1'b0; ns[c] = 0; mrise[c] = 1'b0; mfall[c] = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 2; c++) begin
      bit raw, s, all_opp;
      raw = (c == 0) ? bus.sw_a_raw : bus.sw_b_raw;
      mrise[c] = 1'b0;
      mfall[c] = 1'b0;
      if (!rst_n) begin
        rh[c][0] = 1'b0;
        rh[c][1] = 1'b0;
        ns[c]    = 0;
        mout[c]  = 1'b0;
      end else begin
        s        = rh[c][1];
        rh[c][1] = rh[c][0];
        rh[c][0] = raw;
        for (int i = Win - 1; i > 0; i--) win[c][i] = win[c][i-1];
        win[c][0] = s;
        if (ns[c] < Win) ns[c]++;
        all_opp = (ns[c] >= int'(D) + 1);
        for (int i = 0; i <= int'(D); i++) if (win[c][i] == mout[c]) all_opp = 1'b0;
        if (all_opp) begin
          mrise[c] = !mout[c];
          mfall[c] = mout[c];
          mout[c]  = !mout[c];
        end
      end
    end
    chk("model_a_out",  bus.a_out,  mout[0]);
    chk("model_b_out",  bus.b_out,  mout[1]);
    chk("model_a_rise", bus.a_rise, EdgeEn & mrise[0]);
    chk("model_a_fall", bus.a_fall, EdgeEn & mfall[0]);
    chk("model_b_rise", bus.b_rise, EdgeEn & mrise[1]);
    chk("model_b_fall", bus.b_fall, EdgeEn & mfall[1]);
  end

  initial begin
    int cnt_rise;
    int bad;
    int pct;

    // Reset with both raws high; release and expect rise at edge 6.
    rst_n = 1'b0;
    bus.sw_a_raw = 1'b1;
    bus.sw_b_raw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_a_out",  bus.a_out,  1'b0);
      chk("rst_b_out",  bus.b_out,  1'b0);
      chk("rst_a_rise", bus.a_rise, 1'b0);
      chk("rst_b_fall", bus.b_fall, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) chk("post_rst_a_e5", bus.a_out, 1'b0);
      if (k == 6) begin
        chk("post_rst_a_e6", bus.a_out, 1'b1);
        chk("post_rst_b_e6", bus.b_out, 1'b1);
      end
    end
    bus.sw_a_raw = 1'b0;
    bus.sw_b_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("settle_a_low", bus.a_out, 1'b0);

    // Clean step on A.
    bus.sw_a_raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) chk("step_a_e5", bus.a_out, 1'b0);
      if (k == 6) begin
        chk("step_a_e6", bus.a_out, 1'b1);
        chk("step_rise_e6", bus.a_rise, EdgeEn);
      end
      if (k == 7) chk("step_rise_e7", bus.a_rise, 1'b0);
      chk("step_b_low", bus.b_out, 1'b0);
    end
    bus.sw_a_raw = 1'b0;
    repeat (12) @(negedge clk);

    // Bounce 1,0,1,0 then hold 1.
    cnt_rise = 0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      bus.sw_a_raw = (k % 2 == 0);
      @(negedge clk);
      if (bus.a_rise) cnt_rise++;
      if (bus.a_out) bad++;
    end
    bus.sw_a_raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (bus.a_rise) cnt_rise++;
      if (k <= 5 && bus.a_out) bad++;
      if (k == 6) chk("bounce_a_e6", bus.a_out, 1'b1);
    end
    chk("bounce_no_early", bad == 0, 1'b1);
    chk("bounce_one_rise", cnt_rise == int'(EdgeEn), 1'b1);
    bus.sw_a_raw = 1'b0;
    repeat (12) @(negedge clk);

    // Glitch on B: 3 cycles high.
    bad = 0;
    bus.sw_b_raw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.b_out || bus.b_rise) bad++;
    end
    bus.sw_b_raw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.b_out || bus.b_rise) bad++;
    end
    chk("glitch_b_stays_low", bad == 0, 1'b1);

    // Simultaneous rise at edge 0, fall captured at edge 20.
    bus.sw_a_raw = 1'b1;
    bus.sw_b_raw = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (k == 19) begin
        bus.sw_a_raw = 1'b0;
        bus.sw_b_raw = 1'b0;
      end
      if (k == 5) chk("sim_a_e5", bus.a_out, 1'b0);
      if (k == 6) begin
        chk("sim_a_e6", bus.a_out, 1'b1);
        chk("sim_b_e6", bus.b_out, 1'b1);
        chk("sim_b_rise_e6", bus.b_rise, EdgeEn);
      end
      if (k == 25) chk("sim_b_e25", bus.b_out, 1'b1);
      if (k == 26) begin
        chk("sim_a_e26", bus.a_out, 1'b0);
        chk("sim_b_e26", bus.b_out, 1'b0);
        chk("sim_a_fall_e26", bus.a_fall, EdgeEn);
        chk("sim_b_fall_e26", bus.b_fall, EdgeEn);
      end
      if (k == 27) chk("sim_a_fall_e27", bus.a_fall, 1'b0);
    end
    repeat (4) @(negedge clk);

    // Reset at edge 4 of a pending rise; restart from edge 6.
    bus.sw_a_raw = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b0;
      if (k == 5) rst_n = 1'b1;
      if (k == 6)  chk("rstw_a_e6", bus.a_out, 1'b0);
      if (k == 11) chk("rstw_a_e11", bus.a_out, 1'b0);
      if (k == 12) chk("rstw_a_e12", bus.a_out, 1'b1);
    end

    // Random phase with varying bounce density and rare resets.
    pct = 5;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n % 200 == 0) pct = (n % 600 == 0) ? 3 : ((n % 600 == 200) ? 12 : 40);
      if ($urandom_range(0, 99) < pct) bus.sw_a_raw = !bus.sw_a_raw;
      if ($urandom_range(0, 99) < pct) bus.sw_b_raw = !bus.sw_b_raw;
      rst_n = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
